aes_spi_scheduler: RTL and testbench

- Arbitrates between an encrypt requester and a decrypt requester for one shared SPI link to the Cipher and InvCipher slaves.
- Grants one request at a time and asserts the matching chip select.
- Shifts the 128-bit block out MSB-first, waits for the slave's completion strobe, then shifts the 128-bit result back in.
- Returns the result to the granted requester. Sits between the system bus glue and the SPI slaves, replacing ad-hoc master sequencing.

---
 rtl/aes_spi_pkg.sv | 8 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/aes_spi_scheduler.sv | 130 +++++++++++++
 tb/tb_aes_spi_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: shared types and constants for the AES SPI scheduler
// Contents: scheduler FSM state enum, default block width, owner encoding.
package aes_spi_pkg;
   localparam int DATA_W_DEF = 128;
   localparam logic OWN_ENC = 1'b0;
   localparam logic OWN_DEC = 1'b1;
   typedef enum logic [2:0] {IDLE, SHIFT_OUT, WAIT, SHIFT_IN, DONE} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter with a registered priority pointer
// Ports: clk_divided/rst (async, active-high) clock and reset; i_req[1:0] requests
// (bit 0 encrypt, bit 1 decrypt); i_accept grant-taken strobe; o_gnt[1:0] one-hot grant.
module rr_arbiter2 import aes_spi_pkg::*; (
   input  logic       clk_divided,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_accept,
   output logic [1:0] o_gnt
);
   logic r_ptr;
   // r_ptr names the side that wins a tie
   always_comb o_gnt = {i_req[1] & (r_ptr | ~i_req[0]), i_req[0] & (~r_ptr | ~i_req[1])};
   // after a grant the tie goes to the side that was not just served
   always_ff @(posedge clk_divided or posedge rst)
      if (rst) r_ptr <= OWN_ENC;
      else if (i_accept) r_ptr <= o_gnt[1] ? OWN_ENC : OWN_DEC;
endmodule

// File: rtl/aes_spi_scheduler.sv
// aes_spi_scheduler: arbitrates encrypt/decrypt requesters onto one SPI link to the Cipher/InvCipher slaves
// Ports: clk_divided/rst (async, active-high); i_enc_req/i_enc_din/o_enc_ack and i_dec_req/i_dec_din/o_dec_ack
// requester handshakes; o_dout result register; o_cs_enc/o_cs_dec slave selects; o_mosi/i_miso serial data;
// i_slave_done slave completion; o_busy not idle; o_err sticky WAIT timeout (only with AES_SPI_SCHED_TIMEOUT_EN).
module aes_spi_scheduler import aes_spi_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W = $clog2(DATA_W)
`ifdef AES_SPI_SCHED_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic              clk_divided,
   input  logic              rst,
   input  logic              i_enc_req,
   input  logic [DATA_W-1:0] i_enc_din,
   output logic              o_enc_ack,
   input  logic              i_dec_req,
   input  logic [DATA_W-1:0] i_dec_din,
   output logic              o_dec_ack,
   output logic [DATA_W-1:0] o_dout,
   output logic              o_cs_enc,
   output logic              o_cs_dec,
   output logic              o_mosi,
   input  logic              i_miso,
   input  logic              i_slave_done,
   output logic              o_busy
`ifdef AES_SPI_SCHED_TIMEOUT_EN
   , output logic            o_err
`endif
);
   state_t            r_state;
   logic [DATA_W-1:0] r_sr;
   logic [DATA_W-1:0] r_dout;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_own;
   logic              r_cs_enc;
   logic              r_cs_dec;
   logic              r_enc_ack;
   logic              r_dec_ack;
   logic [1:0]        w_gnt;
   logic              w_accept;
`ifdef AES_SPI_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0]   r_tcnt;
   logic              r_err;
   assign o_err = r_err;
`endif
   assign w_accept  = (r_state == IDLE) & (|w_gnt);
   assign o_busy    = r_state != IDLE;
   assign o_mosi    = (r_state == SHIFT_OUT) & r_sr[DATA_W-1];
   assign o_dout    = r_dout;
   assign o_cs_enc  = r_cs_enc;
   assign o_cs_dec  = r_cs_dec;
   assign o_enc_ack = r_enc_ack;
   assign o_dec_ack = r_dec_ack;
   rr_arbiter2 u_arb (
      .clk_divided(clk_divided),
      .rst        (rst),
      .i_req      ({i_dec_req, i_enc_req}),
      .i_accept   (w_accept),
      .o_gnt      (w_gnt)
   );
   always_ff @(posedge clk_divided or posedge rst)
      if (rst) begin
         r_state   <= IDLE;
         r_sr      <= '0;
         r_dout    <= '0;
         r_cnt     <= '0;
         r_own     <= OWN_ENC;
         r_cs_enc  <= 1'b0;
         r_cs_dec  <= 1'b0;
         r_enc_ack <= 1'b0;
         r_dec_ack <= 1'b0;
`ifdef AES_SPI_SCHED_TIMEOUT_EN
         r_tcnt    <= '0;
         r_err     <= 1'b0;
`endif
      end else begin
         r_enc_ack <= 1'b0;
         r_dec_ack <= 1'b0;
         case (r_state)
            IDLE:
               if (|w_gnt) begin
                  r_own    <= w_gnt[1] ? OWN_DEC : OWN_ENC;
                  r_sr     <= w_gnt[1] ? i_dec_din : i_enc_din;
                  r_cnt    <= CNT_W'(DATA_W - 1);
                  r_cs_enc <= w_gnt[0];
                  r_cs_dec <= w_gnt[1];
                  r_state  <= SHIFT_OUT;
`ifdef AES_SPI_SCHED_TIMEOUT_EN
                  r_tcnt   <= '0;
                  r_err    <= 1'b0;
`endif
               end
            SHIFT_OUT: begin
               r_sr  <= r_sr << 1;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == '0) r_state <= WAIT;
            end
            WAIT:
               if (i_slave_done) begin
                  r_cnt   <= CNT_W'(DATA_W - 1);
                  r_state <= SHIFT_IN;
               end
`ifdef AES_SPI_SCHED_TIMEOUT_EN
               // abandon the transaction: no ack and the previous result stays in dout
               else if (r_tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  r_cs_enc <= 1'b0;
                  r_cs_dec <= 1'b0;
                  r_err    <= 1'b1;
                  r_state  <= IDLE;
               end else r_tcnt <= r_tcnt + 1'b1;
`endif
            SHIFT_IN: begin
               r_sr  <= {r_sr[DATA_W-2:0], i_miso};
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == '0) r_state <= DONE;
            end
            DONE: begin
               r_dout    <= r_sr;
               r_enc_ack <= r_own == OWN_ENC;
               r_dec_ack <= r_own == OWN_DEC;
               r_cs_enc  <= 1'b0;
               r_cs_dec  <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_aes_spi_scheduler.sv
// tb_aes_spi_scheduler: directed scoreboard bench for aes_spi_scheduler with an SPI slave model
module tb_aes_spi_scheduler;
   localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] VA = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] VB = 128'hdeadbeef00000001cafef00d5555aaaa;
   localparam logic [127:0] VC = 128'h8000000000000000000000000000ffff;
   localparam logic [127:0] VD = 128'h13579bdf2468ace00f0f0f0ff0f0f0f0;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enc_req = 1'b0, dec_req = 1'b0;
   logic [127:0] enc_din = '0, dec_din = '0;
   logic enc_ack, dec_ack, cs_enc, cs_dec, mosi, busy;
   logic miso = 1'b0, slave_done = 1'b0;
   logic [127:0] dout;
`ifdef AES_SPI_SCHED_TIMEOUT_EN
   logic err;
`endif
   always #5 clk = ~clk;
   aes_spi_scheduler #(
      .DATA_W(128)
`ifdef AES_SPI_SCHED_TIMEOUT_EN
      , .TIMEOUT_CYCLES(16)
`endif
   ) dut (
      .clk_divided (clk),
      .rst         (rst),
      .i_enc_req   (enc_req),
      .i_enc_din   (enc_din),
      .o_enc_ack   (enc_ack),
      .i_dec_req   (dec_req),
      .i_dec_din   (dec_din),
      .o_dec_ack   (dec_ack),
      .o_dout      (dout),
      .o_cs_enc    (cs_enc),
      .o_cs_dec    (cs_dec),
      .o_mosi      (mosi),
      .i_miso      (miso),
      .i_slave_done(slave_done),
      .o_busy      (busy)
`ifdef AES_SPI_SCHED_TIMEOUT_EN
      , .o_err     (err)
`endif
   );
   typedef struct {logic own; logic [127:0] data;} exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0;
   int cyc = 0, gcyc = 0, enc_acks = 0, dec_acks = 0;
   int k = 0, wait_n = 20, spur_k = -1, last_cs_len = 0;
   bit no_done = 1'b0, bad_own = 1'b0;
   logic cur_own = 1'b0, pbusy = 1'b0;
   logic [127:0] rx = '0, tx = '0, last_rx = '0, pdout = '0;
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [127:0] resp(input logic own, input logic [127:0] d);
      if (d == PT) return CT;
      return own ? {d[63:0], d[127:64]} : ~d;
   endfunction
   always @(posedge clk) cyc <= cyc + 1;
   // slave: samples mosi, raises slave_done on the wait_n-th WAIT cycle, then returns resp() MSB-first
   initial forever begin
      @(negedge clk);
      slave_done = 1'b0;
      miso = 1'b0;
      if (cs_enc | cs_dec) begin
         if (k == 0) cur_own = cs_dec;
         else if (cs_dec != cur_own) bad_own = 1'b1;
         if (k < 128) begin
            rx = {rx[126:0], mosi};
            if (k == 127) begin
               last_rx = rx;
               tx = resp(cur_own, rx);
            end
            if (k == spur_k) slave_done = 1'b1;
         end else if (k < 128 + wait_n) slave_done = (k == 127 + wait_n) && !no_done;
         else if (k < 256 + wait_n) miso = tx[127-(k-128-wait_n)];
         k++;
      end else begin
         if (k > 0) last_cs_len = k;
         k = 0;
      end
   end
   // monitor: select invariant, scoreboard on acks, grant-to-ack latency, dout stability
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst) begin
         if (busy && !pbusy) gcyc = cyc - 1;
         chk("cs_onehot", {127'b0, cs_enc & cs_dec}, '0);
         if (enc_ack | dec_ack) begin
            enc_acks += int'(enc_ack);
            dec_acks += int'(dec_ack);
            if (sb.size() == 0) chk("unexpected_ack", {126'b0, enc_ack, dec_ack}, '0);
            else begin
               e = sb.pop_front();
               chk("ack_owner", {126'b0, enc_ack, dec_ack}, e.own ? 128'd1 : 128'd2);
               chk("dout", dout, e.data);
               chk("latency", 128'(cyc - gcyc), 128'(2 * 128 + wait_n + 2));
            end
         end else chk("dout_hold", dout, pdout);
      end
      pbusy = busy;
      pdout = dout;
   end
   task automatic wait_ack(input logic own, input string tag);
      int t = 0;
      while (!(own ? dec_ack : enc_ack) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_ack_in_time"}, {127'b0, t < 2000}, 128'd1);
      if (own) dec_req = 1'b0;
      else enc_req = 1'b0;
   endtask
   task automatic push(input logic own, input logic [127:0] d);
      exp_t e;
      e.own = own;
      e.data = resp(own, d);
      sb.push_back(e);
   endtask
   initial begin
      int t, e0, d0;
      logic [127:0] hold;
      repeat (3) @(negedge clk);
      chk("rst_cs", {126'b0, cs_enc, cs_dec}, '0);
      chk("rst_ack", {126'b0, enc_ack, dec_ack}, '0);
      chk("rst_mosi_busy", {126'b0, mosi, busy}, '0);
      chk("rst_dout", dout, '0);
`ifdef AES_SPI_SCHED_TIMEOUT_EN
      chk("rst_err", {127'b0, err}, '0);
`endif
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", {127'b0, busy}, '0);
      // simultaneous pair after reset: encrypt first
      enc_din = VA; dec_din = VB;
      push(1'b0, VA); push(1'b1, VB);
      enc_req = 1'b1; dec_req = 1'b1;
      wait_ack(1'b0, "pair1_enc");
      wait_ack(1'b1, "pair1_dec");
      // single encrypt with the reference vector
      e0 = enc_acks;
      enc_din = PT;
      push(1'b0, PT);
      enc_req = 1'b1;
      wait_ack(1'b0, "single");
      @(negedge clk);
      chk("single_mosi", last_rx, PT);
      chk("single_cs_len", 128'(last_cs_len), 128'd277);
      chk("single_cs_owner", {127'b0, bad_own}, '0);
      chk("single_enc_acks", 128'(enc_acks - e0), 128'd1);
      // next simultaneous pair: decrypt favoured
      enc_din = VC; dec_din = VD;
      push(1'b1, VD); push(1'b0, VC);
      enc_req = 1'b1; dec_req = 1'b1;
      wait_ack(1'b1, "pair2_dec");
      wait_ack(1'b0, "pair2_enc");
      // back-to-back decrypts with req held through the first ack
      e0 = enc_acks; d0 = dec_acks;
      wait_n = 7;
      dec_din = VA;
      push(1'b1, VA); push(1'b1, VA);
      dec_req = 1'b1;
      t = 0;
      while (!dec_ack && t < 2000) begin @(negedge clk); t++; end
      chk("b2b_first_ack", {127'b0, dec_ack}, 128'd1);
      @(negedge clk);
      chk("b2b_regrant", {126'b0, cs_dec, busy}, 128'd3);
      wait_ack(1'b1, "b2b_second");
      @(negedge clk);
      chk("b2b_dec_acks", 128'(dec_acks - d0), 128'd2);
      chk("b2b_enc_acks", 128'(enc_acks - e0), '0);
      // spurious slave_done during SHIFT_OUT
      wait_n = 5; spur_k = 50;
      enc_din = VB;
      push(1'b0, VB);
      enc_req = 1'b1;
      wait_ack(1'b0, "spurious");
      @(negedge clk);
      chk("spurious_cs_len", 128'(last_cs_len), 128'(257 + 5));
      spur_k = -1; wait_n = 20;
      // reset while receiving result bit 60
      enc_din = VC;
      push(1'b0, VC);
      enc_req = 1'b1;
      t = 0;
      while (k != 128 + wait_n + 60 && t < 2000) begin @(negedge clk); #1; t++; end
      chk("midrst_reached", {127'b0, t < 2000}, 128'd1);
      rst = 1'b1;
      #1;
      chk("midrst_cs", {126'b0, cs_enc, cs_dec}, '0);
      chk("midrst_ack", {126'b0, enc_ack, dec_ack}, '0);
      chk("midrst_dout", dout, '0);
      chk("midrst_busy", {127'b0, busy}, '0);
      sb.delete();
      enc_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      dec_din = VD;
      push(1'b1, VD);
      dec_req = 1'b1;
      wait_ack(1'b1, "after_rst");
`ifdef AES_SPI_SCHED_TIMEOUT_EN
      // no slave_done: abandon after 16 WAIT cycles
      @(negedge clk);
      hold = dout;
      no_done = 1'b1; wait_n = 1000;
      enc_din = VA;
      enc_req = 1'b1;
      @(negedge clk);
      enc_req = 1'b0;
      t = 0;
      while (busy && t < 1000) begin @(negedge clk); t++; end
      chk("to_idle", {127'b0, busy}, '0);
      @(negedge clk);
      chk("to_cs_len", 128'(last_cs_len), 128'(128 + 16));
      chk("to_err", {127'b0, err}, 128'd1);
      chk("to_dout", dout, hold);
      no_done = 1'b0; wait_n = 20;
      enc_din = VB;
      push(1'b0, VB);
      enc_req = 1'b1;
      @(negedge clk);
      chk("to_err_clear", {127'b0, err}, '0);
      wait_ack(1'b0, "to_recover");
`endif
      repeat (3) @(negedge clk);
      chk("sb_empty", 128'(sb.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
